// File: rtl/multiword_add_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : multiword_add_sequencer_if
//  Brief    : Operand/result handshake bundle for multiword_add_sequencer.
//             Optional ovf signal present when SEQ_OVERFLOW_EN is defined.
//  Revision : 1.0
// ============================================================================
interface multiword_add_sequencer_if #(
    parameter int WORD_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              cin;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] sum;
    logic              cout;
`ifdef SEQ_OVERFLOW_EN
    logic              ovf;
`endif

    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  cout
`ifdef SEQ_OVERFLOW_EN
        ,
        input  ovf
`endif
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output cout
`ifdef SEQ_OVERFLOW_EN
        ,
        output ovf
`endif
    );
endinterface
`default_nettype wire

// File: rtl/multiword_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : multiword_add_sequencer
//  Brief    : Sequential wide adder, one carry-select CHUNK_W slice per clock.
//             Define SEQ_OVERFLOW_EN to add the signed-overflow output ovf.
//  Revision : 1.0
// ============================================================================
module multiword_add_sequencer #(
    parameter int WORD_W  = 32,
    parameter int CHUNK_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    multiword_add_sequencer_if.slave bus
);
    localparam int NCHUNK = WORD_W / CHUNK_W;
    localparam int CNT_W  = (NCHUNK > 2) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NCHUNK - 1);

    generate
        if (((WORD_W % CHUNK_W) != 0) || (NCHUNK < 2)) begin : g_bad_params
            $error("multiword_add_sequencer: WORD_W must be a multiple of CHUNK_W with at least two slices");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WORD_W-1:0]   r_a;
    logic [WORD_W-1:0]   r_b;
    logic [WORD_W-1:0]   r_sum;
    logic                r_carry;
    logic                r_cout;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_accept;
    logic                w_last;
    logic                w_in_ready;
    logic                w_out_valid;
    logic [31:0]         w_base;
    logic [CHUNK_W-1:0]  w_a_slice;
    logic [CHUNK_W-1:0]  w_b_slice;
    logic [CHUNK_W:0]    w_sel0;
    logic [CHUNK_W:0]    w_sel1;
    logic [CHUNK_W:0]    w_slice;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_last = (r_state == S_RUN) && (r_cnt == C_LAST);

    // Carry-select slice: both candidate sums exist before the carry resolves.
    assign w_base    = 32'(r_cnt) * 32'(CHUNK_W);
    assign w_a_slice = r_a[w_base +: CHUNK_W];
    assign w_b_slice = r_b[w_base +: CHUNK_W];
    assign w_sel0    = {1'b0, w_a_slice} + {1'b0, w_b_slice};
    assign w_sel1    = {1'b0, w_a_slice} + {1'b0, w_b_slice} + (CHUNK_W+1)'(1);
    assign w_slice   = r_carry ? w_sel1 : w_sel0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_sum   <= '0;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_sum[w_base +: CHUNK_W] <= w_slice[CHUNK_W-1:0];
            r_carry                  <= w_slice[CHUNK_W];
            if (w_last) begin
                r_cout <= w_slice[CHUNK_W];
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
            end
        end
    end

`ifdef SEQ_OVERFLOW_EN
    logic r_ovf;
    logic w_msb_carry_in;

    // The carry into the top bit is recovered from its own sum bit.
    assign w_msb_carry_in = w_a_slice[CHUNK_W-1] ^ w_b_slice[CHUNK_W-1] ^ w_slice[CHUNK_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= w_msb_carry_in ^ w_slice[CHUNK_W];
        end
    end

    assign bus.ovf = r_ovf;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
endmodule
`default_nettype wire

// File: tb/tb_multiword_add_sequencer.sv
`default_nettype none
// Testbench for multiword_add_sequencer: 8-bit/4-bit instance plus a default 32-bit instance,
// scoreboard of expected results checked at each output handshake.
module tb_multiword_add_sequencer;
    logic clk = 1'b0;
    logic rst;
    logic sel;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multiword_add_sequencer_if #(.WORD_W(8))  bus8 ();
    multiword_add_sequencer_if #(.WORD_W(32)) bus32 ();

    multiword_add_sequencer #(.WORD_W(8), .CHUNK_W(4)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    multiword_add_sequencer dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32)
    );

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    logic        obs_in_ready;
    logic        obs_out_valid;
    logic [31:0] obs_sum;
    logic        obs_cout;
    assign obs_in_ready  = sel ? bus32.in_ready  : bus8.in_ready;
    assign obs_out_valid = sel ? bus32.out_valid : bus8.out_valid;
    assign obs_sum       = sel ? bus32.sum       : {24'h0, bus8.sum};
    assign obs_cout      = sel ? bus32.cout      : bus8.cout;
`ifdef SEQ_OVERFLOW_EN
    logic obs_ovf;
    assign obs_ovf = sel ? bus32.ovf : bus8.ovf;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic [31:0] a, input logic [31:0] b, input logic cin);
        if (sel) begin
            bus32.in_valid = valid;
            bus32.a        = a;
            bus32.b        = b;
            bus32.cin      = cin;
        end else begin
            bus8.in_valid = valid;
            bus8.a        = a[7:0];
            bus8.b        = b[7:0];
            bus8.cin      = cin;
        end
    endtask

    task automatic set_out_ready(input logic r);
        if (sel) bus32.out_ready = r;
        else     bus8.out_ready  = r;
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input int hold, input int exp_lat);
        logic [31:0] am;
        logic [31:0] bm;
        logic [32:0] full;
        exp_t        e;
        int          w;
        int          lat;
        w    = sel ? 32 : 8;
        am   = sel ? a : {24'h0, a[7:0]};
        bm   = sel ? b : {24'h0, b[7:0]};
        full = {1'b0, am} + {1'b0, bm} + 33'(cin);
        e.sum  = sel ? full[31:0] : {24'h0, full[7:0]};
        e.cout = full[w];
        e.ovf  = (am[w-1] == bm[w-1]) && (e.sum[w-1] != am[w-1]);
        sb.push_back(e);

        set_out_ready(hold == 0);
        drive(1'b1, a, b, cin);
        check("in_ready_before_accept", 64'(obs_in_ready), 64'd1);
        tick();
        drive(1'b0, a, b, cin);
        check("in_ready_busy", 64'(obs_in_ready), 64'd0);

        lat = 0;
        while (!obs_out_valid && lat < 50) begin
            tick();
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));

        for (int i = 0; i < hold; i++) begin
            drive(1'b1, 32'h10, 32'h20, 1'b0);
            tick();
            check("held_out_valid", 64'(obs_out_valid), 64'd1);
            check("held_in_ready", 64'(obs_in_ready), 64'd0);
            check("held_sum", 64'(obs_sum), 64'(sb[0].sum));
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        set_out_ready(1'b1);

        e = sb.pop_front();
        check("sum", 64'(obs_sum), 64'(e.sum));
        check("cout", 64'(obs_cout), 64'(e.cout));
`ifdef SEQ_OVERFLOW_EN
        check("ovf", 64'(obs_ovf), 64'(e.ovf));
`endif
        tick();
        check("out_valid_after_handshake", 64'(obs_out_valid), 64'd0);
        check("in_ready_after_handshake", 64'(obs_in_ready), 64'd1);
        set_out_ready(1'b0);
    endtask

    initial begin
        sel = 1'b0;
        rst = 1'b1;
        bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0; bus8.out_ready  = 1'b0;
        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 64'(obs_in_ready), 64'd1);
        check("rst_out_valid", 64'(obs_out_valid), 64'd0);
        check("rst_sum", 64'(obs_sum), 64'd0);
        check("rst_cout", 64'(obs_cout), 64'd0);
`ifdef SEQ_OVERFLOW_EN
        check("rst_ovf", 64'(obs_ovf), 64'd0);
`endif
        rst = 1'b0;

        do_op(32'h06, 32'h06, 1'b0, 0, 2);
        do_op(32'hFF, 32'h01, 1'b0, 0, 2);
        do_op(32'h2E, 32'h79, 1'b1, 5, 2);

        // Reset during RUN, after slice 0 has been processed.
        drive(1'b1, 32'h55, 32'hAA, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", 64'(obs_in_ready), 64'd1);
        check("midrst_sum", 64'(obs_sum), 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("midrst_out_valid", 64'(obs_out_valid), 64'd0);
            tick();
        end
        do_op(32'h10, 32'h20, 1'b0, 0, 2);

        do_op(32'h7F, 32'h01, 1'b0, 0, 2);
        do_op(32'hFF, 32'h01, 1'b0, 0, 2);

        sel = 1'b1;
        do_op(32'hFFFFFFFF, 32'h0, 1'b1, 0, 8);
        do_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 3, 8);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
